io_host_link: RTL and testbench

- External-side endpoint of the MCU's 8-bit IO port; connects `io_output`/`io_input` to a host through ready/valid streams.
- Bytes the MCU writes on its IO port are captured into a small FIFO and drained by the host.
- Bytes offered by the host are held in a single-entry register presented on the MCU's `io_input` until the MCU consumes them.

---
 rtl/io_host_link.sv | 161 ++++++++++++++++
 tb/tb_io_host_link.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_host_link.sv
// io_host_link
//   External-side endpoint of an MCU 8-bit IO port. Bytes the MCU writes are
//   queued in a small output FIFO that the host drains over a ready/valid
//   stream. Bytes offered by the host are held in a single-entry register and
//   presented on the MCU's io_input until the MCU reads them.
//
// Optional feature: define IO_HOST_LOOPBACK_EN to add the `loopback` input.
//   With loopback=1, MCU writes are routed into the input holding register
//   instead of the FIFO. Such a write is dropped, and overflow is set, when the
//   register is already FULL. host_in_ready is held at 0, and the FIFO keeps
//   draining to the host.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   mcu_io_output     byte written by the MCU (qualified by mcu_io_write)
//   mcu_io_write      one-cycle MCU write strobe
//   mcu_io_read       one-cycle MCU read strobe (consumes mcu_io_input)
//   mcu_io_input      held byte presented to the MCU (0 when none)
//   in_avail          holding register has an unread byte
//   host_out_*        output FIFO stream toward the host
//   host_in_*         input stream from the host into the holding register
//   out_count         output FIFO occupancy, 0..DEPTH
//   overflow          sticky drop flag; overflow_clr clears it (set wins)
//   loopback          (IO_HOST_LOOPBACK_EN only) route MCU writes back to MCU
module io_host_link #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
`ifdef IO_HOST_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic [7:0]        mcu_io_output,
  input  logic              mcu_io_write,
  input  logic              mcu_io_read,
  output logic [7:0]        mcu_io_input,
  output logic              in_avail,
  output logic [7:0]        host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  input  logic [7:0]        host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [ADDR_W:0]   out_count,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IN_EMPTY = 1'b0, IN_FULL = 1'b1} in_state_t;

  logic loop_active;
`ifdef IO_HOST_LOOPBACK_EN
  assign loop_active = loopback;
`else
  assign loop_active = 1'b0;
`endif

  // ---------------------------------------------------------------- output FIFO
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              overflow_reg;

  logic push_req, push, pop, fifo_drop, loop_drop;

  assign host_out_valid = (count_reg != '0);
  assign host_out_data  = host_out_valid ? mem[rd_ptr_reg] : 8'h00;
  assign out_count      = count_reg;
  assign overflow       = overflow_reg;

  assign push_req  = mcu_io_write && !loop_active;
  assign pop       = host_out_valid && host_out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push      = push_req && ((count_reg != COUNT_FULL) || pop);
  assign fifo_drop = push_req && !push;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= mcu_io_output;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
      // Set has priority over a simultaneous clear.
      if (fifo_drop || loop_drop)
        overflow_reg <= 1'b1;
      else if (overflow_clr)
        overflow_reg <= 1'b0;
    end
  end

  // --------------------------------------------------------- input holding FSM
  in_state_t  state_reg, state_next;
  logic [7:0] held_reg, held_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IN_EMPTY;
      held_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      held_reg  <= held_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    held_next     = held_reg;
    host_in_ready = 1'b0;
    in_avail      = 1'b0;
    mcu_io_input  = 8'h00;
    loop_drop     = 1'b0;
    case (state_reg)
      IN_EMPTY: begin
        host_in_ready = !loop_active;
        if (loop_active) begin
          if (mcu_io_write) begin
            held_next  = mcu_io_output;
            state_next = IN_FULL;
          end
        end else if (host_in_valid) begin
          held_next  = host_in_data;
          state_next = IN_FULL;
        end
      end
      IN_FULL: begin
        in_avail     = 1'b1;
        mcu_io_input = held_reg;
        // A host offer in this state is never taken, even alongside a read;
        // it can be captured on the following cycle at the earliest.
        loop_drop    = loop_active && mcu_io_write;
        if (mcu_io_read) begin
          held_next  = 8'h00;
          state_next = IN_EMPTY;
        end
      end
      default: begin
        state_next = IN_EMPTY;
        held_next  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_io_host_link.sv
module tb_io_host_link;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            loopback;
  logic [7:0]      mcu_io_output;
  logic            mcu_io_write;
  logic            mcu_io_read;
  logic [7:0]      mcu_io_input;
  logic            in_avail;
  logic [7:0]      host_out_data;
  logic            host_out_valid;
  logic            host_out_ready;
  logic [7:0]      host_in_data;
  logic            host_in_valid;
  logic            host_in_ready;
  logic [ADDR_W:0] out_count;
  logic            overflow;
  logic            overflow_clr;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  io_host_link #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef IO_HOST_LOOPBACK_EN
    .loopback       (loopback),
`endif
    .mcu_io_output  (mcu_io_output),
    .mcu_io_write   (mcu_io_write),
    .mcu_io_read    (mcu_io_read),
    .mcu_io_input   (mcu_io_input),
    .in_avail       (in_avail),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .out_count      (out_count),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mcu_write(input logic [7:0] b, input bit accept);
    mcu_io_output = b;
    mcu_io_write  = 1'b1;
    if (accept) exp_q.push_back(b);
    tick();
    mcu_io_write  = 1'b0;
  endtask

  task automatic drain(input string tag);
    host_out_ready = 1'b1;
    for (int i = 0; i < 20 && out_count != 0; i++) tick();
    host_out_ready = 1'b0;
    check(tag, out_count, 0);
  endtask

  // Scoreboard: a handshake seen mid-cycle pops at the next rising edge.
  always @(negedge clk) begin
    if (reset && host_out_valid && host_out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", host_out_data, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("sb_data", host_out_data, e);
        $display("host pop %02h (expected %02h)", host_out_data, e);
      end
    end
  end

  initial begin
    reset = 1'b0; loopback = 1'b0;
    mcu_io_output = 8'h00; mcu_io_write = 1'b0; mcu_io_read = 1'b0;
    host_out_ready = 1'b0; host_in_data = 8'h00; host_in_valid = 1'b0;
    overflow_clr = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_count", out_count, 0);
    check("rst_valid", host_out_valid, 0);
    check("rst_data", host_out_data, 8'h00);
    check("rst_ovf", overflow, 0);
    check("rst_avail", in_avail, 0);
    check("rst_input", mcu_io_input, 8'h00);
    check("rst_hready", host_in_ready, 1);

    // Reset mid-traffic: 3 queued bytes and a held byte are discarded.
    mcu_write(8'hE1, 1'b0);
    mcu_write(8'hE2, 1'b0);
    mcu_write(8'hE3, 1'b0);
    host_in_data = 8'h33; host_in_valid = 1'b1;
    tick();
    host_in_valid = 1'b0;
    check("pre_rst_count", out_count, 3);
    check("pre_rst_avail", in_avail, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_count", out_count, 0);
    check("arst_valid", host_out_valid, 0);
    check("arst_avail", in_avail, 0);
    check("arst_input", mcu_io_input, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_hready", host_in_ready, 1);
    check("post_rst_count", out_count, 0);

    // Three back-to-back writes, then drain in order.
    mcu_write(8'hA1, 1'b1);
    mcu_write(8'hB2, 1'b1);
    mcu_write(8'hC3, 1'b1);
    check("abc_count", out_count, 3);
    check("abc_head", host_out_data, 8'hA1);
    check("abc_valid", host_out_valid, 1);
    host_out_ready = 1'b1;
    repeat (3) tick();
    host_out_ready = 1'b0;
    check("abc_empty_valid", host_out_valid, 0);
    check("abc_empty_data", host_out_data, 8'h00);

    // Full, drop, write-with-pop at full, sticky overflow and clear.
    for (int i = 0; i < 4; i++) mcu_write(8'h10 + 8'(i), 1'b1);
    mcu_write(8'h14, 1'b0);
    check("full_ovf", overflow, 1);
    check("full_count", out_count, 4);
    check("full_head", host_out_data, 8'h10);
    host_out_ready = 1'b1;
    mcu_write(8'h15, 1'b1);
    host_out_ready = 1'b0;
    check("wpop_count", out_count, 4);
    check("wpop_ovf", overflow, 1);
    check("wpop_head", host_out_data, 8'h11);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    drain("full_drain");

    // Set beats clear in the same cycle.
    for (int i = 0; i < 4; i++) mcu_write(8'h40 + 8'(i), 1'b1);
    overflow_clr = 1'b1;
    mcu_write(8'h44, 1'b0);
    overflow_clr = 1'b0;
    check("set_wins", overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    drain("setwin_drain");

    // Pointer wrap with random ready; write only when it cannot overflow.
    begin
      int n;
      n = 0;
      for (int c = 0; c < 200 && n < 10; c++) begin
        host_out_ready = 1'($urandom_range(0, 1));
        if (out_count != 3'(DEPTH) || host_out_ready) begin
          mcu_write(8'(n), 1'b1);
          n++;
        end else begin
          tick();
        end
      end
      host_out_ready = 1'b0;
      check("wrap_sent", n, 10);
    end
    drain("wrap_drain");
    check("wrap_ovf", overflow, 0);

    // Input holding register.
    host_in_data = 8'h5A; host_in_valid = 1'b1;
    tick();
    host_in_valid = 1'b0;
    check("hin_avail", in_avail, 1);
    check("hin_data", mcu_io_input, 8'h5A);
    check("hin_ready", host_in_ready, 0);
    host_in_data = 8'h6B; host_in_valid = 1'b1; mcu_io_read = 1'b1;
    tick();
    mcu_io_read = 1'b0;
    check("rd_avail", in_avail, 0);
    check("rd_cleared", mcu_io_input, 8'h00);
    check("rd_ready", host_in_ready, 1);
    tick();
    host_in_valid = 1'b0;
    check("cap2_data", mcu_io_input, 8'h6B);
    check("cap2_avail", in_avail, 1);
    host_in_data = 8'h22; host_in_valid = 1'b1;
    tick();
    host_in_valid = 1'b0;
    check("full_hold", mcu_io_input, 8'h6B);
    mcu_io_read = 1'b1;
    tick();
    check("rd2_avail", in_avail, 0);
    tick();
    mcu_io_read = 1'b0;
    check("rd_empty_ign", in_avail, 0);
    check("rd_empty_data", mcu_io_input, 8'h00);

`ifdef IO_HOST_LOOPBACK_EN
    loopback = 1'b1;
    #1;
    check("lb_hready", host_in_ready, 0);
    mcu_write(8'h77, 1'b0);
    check("lb_data", mcu_io_input, 8'h77);
    check("lb_count", out_count, 0);
    mcu_write(8'h88, 1'b0);
    check("lb_drop_ovf", overflow, 1);
    check("lb_drop_data", mcu_io_input, 8'h77);
    mcu_io_read = 1'b1;
    tick();
    mcu_io_read = 1'b0;
    loopback = 1'b0;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("lb_exit", in_avail, 0);
`endif

    check("sb_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
